// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with configurable width and depth.
// Keeps an explicit occupancy count, so every one of the DEPTH entries is usable.
// Provides almost-full/almost-empty thresholds, sticky overflow/underflow flags
// and a synchronous flush.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic                   c,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       i,
    input  logic                   w,
    input  logic                   r,
    input  logic                   clr,
    output logic [WIDTH-1:0]       o,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

    // Pointers carry one extra wrap bit above the index bits.
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic rd_ok;
    logic wr_ok;

    // Flags are decoded from the registered count so they line up with count.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);

    // A write at full is still accepted when a read frees the oldest slot in the same cycle.
    assign rd_ok = r && !empty;
    assign wr_ok = w && (!full || rd_ok);

    assign o     = o_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

    // Next-state logic: flush first, then the accepted read/write and the sticky errors.
    always_comb begin
        // NOTE: every _d is given its hold value first, so no path through this block can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        o_d      = o_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (rd_ok) begin
                o_d      = mem[rd_ptr_q[AW-1:0]];
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + PTR_ONE;
                2'b01:   count_d = count_q - PTR_ONE;
                default: count_d = count_q;
            endcase
            if (w && !wr_ok) ovf_d = 1'b1;
            if (r && empty)  udf_d = 1'b1;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge c or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            o_q      <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the pre-edge state together.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            o_q      <= o_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage write; a flush in the same cycle cancels the write.
    always_ff @(posedge c) begin
        // NOTE: the array has no reset; the empty flag already hides stale contents.
        if (wr_ok && !clr) begin
            mem[wr_ptr_q[AW-1:0]] <= i;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-based reference model plus directed and random stimulus.
module tb_sync_fifo_param;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic             c;
    logic             rst;
    logic [WIDTH-1:0] i;
    logic             w;
    logic             r;
    logic             clr;
    logic [WIDTH-1:0] o;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             ovf;
    logic             udf;

    int checks = 0;
    int errors = 0;

    // Hand-computed expectations for the cycle being driven (-1 means no expectation).
    int exp_count, exp_o, exp_empty, exp_full, exp_af, exp_ovf, exp_udf;

    // Reference model state.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_o;
    logic             m_ovf;
    logic             m_udf;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .c(c), .rst(rst), .i(i), .w(w), .r(r), .clr(clr),
        .o(o), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .count(count), .ovf(ovf), .udf(udf)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_exp();
        exp_count = -1; exp_o = -1; exp_empty = -1; exp_full = -1;
        exp_af = -1; exp_ovf = -1; exp_udf = -1;
    endtask

    // Applies one cycle of inputs at the falling edge; expectations set afterwards refer to the next rising edge.
    task automatic drive(input logic ww, input logic rr, input logic cc, input logic [WIDTH-1:0] d);
        @(negedge c);
        w = ww; r = rr; clr = cc; i = d;
        clear_exp();
    endtask

    // Model update on each edge / reset, then a full comparison 1 time unit later.
    initial begin
        int  n;
        bit  m_rd, m_wr;
        forever begin
            @(posedge c or negedge rst);
            if (!rst) begin
                mq.delete();
                m_o   = '0;
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else if (clr) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                n    = mq.size();
                m_rd = r && (n > 0);
                m_wr = w && ((n < DEPTH) || m_rd);
                if (r && n == 0) m_udf = 1'b1;
                if (w && !m_wr)  m_ovf = 1'b1;
                if (m_rd) m_o = mq.pop_front();
                if (m_wr) mq.push_back(i);
            end
            #1;
            n = mq.size();
            check("o",            32'(o),            32'(m_o));
            check("count",        32'(count),        32'(n));
            check("empty",        32'(empty),        (n == 0) ? 1 : 0);
            check("full",         32'(full),         (n == DEPTH) ? 1 : 0);
            check("almost_empty", 32'(almost_empty), (n <= AE_LEVEL) ? 1 : 0);
            check("almost_full",  32'(almost_full),  (n >= AF_LEVEL) ? 1 : 0);
            check("ovf",          32'(ovf),          32'(m_ovf));
            check("udf",          32'(udf),          32'(m_udf));
            if (exp_count >= 0) check("lit_count", 32'(count),       exp_count);
            if (exp_o >= 0)     check("lit_o",     32'(o),           exp_o);
            if (exp_empty >= 0) check("lit_empty", 32'(empty),       exp_empty);
            if (exp_full >= 0)  check("lit_full",  32'(full),        exp_full);
            if (exp_af >= 0)    check("lit_af",    32'(almost_full), exp_af);
            if (exp_ovf >= 0)   check("lit_ovf",   32'(ovf),         exp_ovf);
            if (exp_udf >= 0)   check("lit_udf",   32'(udf),         exp_udf);
        end
    end

    // Stimulus: directed scenarios followed by biased random traffic.
    initial begin
        int wprob;
        clear_exp();
        rst = 1'b0; w = 1'b0; r = 1'b0; clr = 1'b0; i = '0;
        repeat (2) @(negedge c);
        rst = 1'b1;

        // Idle after reset.
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_o = 0; exp_count = 0; exp_empty = 1; exp_full = 0;
        exp_af = 0; exp_ovf = 0; exp_udf = 0;

        // Fill to full, then overflow.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(k));
            exp_count = k + 1;
            exp_af    = (k + 1 >= 12) ? 1 : 0;
            exp_full  = (k == 15) ? 1 : 0;
        end
        drive(1'b1, 1'b0, 1'b0, 8'hAA);
        exp_ovf = 1; exp_count = 16; exp_full = 1;

        // Drain in order, then underflow.
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            exp_o = k; exp_count = 15 - k; exp_empty = (k == 15) ? 1 : 0;
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_udf = 1; exp_o = 8'h0F; exp_count = 0;

        // Simultaneous read and write at full.
        for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, 1'b0, 8'(k));
        drive(1'b1, 1'b1, 1'b0, 8'h55);
        exp_o = 0; exp_count = 16; exp_full = 1;
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            exp_o = (k < 15) ? k + 1 : 8'h55; exp_count = 15 - k;
        end

        // Flush the sticky flags, then simultaneous read and write at empty.
        drive(1'b0, 1'b0, 1'b1, '0);
        exp_ovf = 0; exp_udf = 0; exp_empty = 1;
        drive(1'b1, 1'b1, 1'b0, 8'h33);
        exp_count = 1; exp_udf = 1; exp_o = 8'h55;
        drive(1'b0, 1'b1, 1'b0, '0);
        exp_o = 8'h33; exp_count = 0;

        // Pointer wrap: alternate write and read.
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(k));
            exp_count = 1;
            drive(1'b0, 1'b1, 1'b0, '0);
            exp_o = k; exp_count = 0;
        end

        // Build count=5 with ovf=1.
        for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, 1'b0, 8'(8'hB0 + k));
        drive(1'b1, 1'b0, 1'b0, 8'hEE);
        exp_ovf = 1; exp_count = 16;
        for (int k = 0; k < 11; k++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            exp_o = 8'hB0 + k;
        end
        exp_count = 5; exp_ovf = 1;

        // Flush together with a write: write ignored, o holds.
        drive(1'b1, 1'b0, 1'b1, 8'h77);
        exp_count = 0; exp_ovf = 0; exp_empty = 1; exp_o = 8'hBA;
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_count = 0; exp_o = 8'hBA;

        // Three writes, then asynchronous reset between edges.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0, 8'(8'hC0 + k));
        drive(1'b0, 1'b0, 1'b0, '0);
        exp_count = 3;
        @(posedge c);
        #3;
        clear_exp();
        exp_count = 0; exp_o = 0; exp_empty = 1; exp_ovf = 0; exp_udf = 0;
        rst = 1'b0;
        @(negedge c);
        drive(1'b0, 1'b0, 1'b0, '0);
        rst = 1'b1;

        // Random traffic, alternating fill-biased and drain-biased phases.
        for (int p = 0; p < 10; p++) begin
            wprob = (p % 2 == 0) ? 80 : 25;
            for (int n = 0; n < 200; n++) begin
                drive(($urandom_range(99) < wprob) ? 1'b1 : 1'b0,
                      ($urandom_range(99) < (100 - wprob)) ? 1'b1 : 1'b0,
                      ($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                      8'($urandom));
            end
        end

        drive(1'b0, 1'b0, 1'b0, '0);
        @(negedge c);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; successor to the team's fixed 4-bit x 16 FIFO.
- Adds configurable width and depth, use of all DEPTH entries, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush.
- Sits between a producer and a consumer on the same clock. Used as the standard buffering element in new datapaths.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of storage entries; power of 2, >=2
AF_LEVEL, 12, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
c  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-low (0 = reset)
i  input  WIDTH  write data
w  input  1  write request
r  input  1  read request
clr  input  1  synchronous flush: empties FIFO and clears error flags
o  output  WIDTH  read data, registered
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
ovf  output  1  sticky: write attempted while full and not accepted
udf  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, asynchronous): read and write pointers = 0, count = 0, o = 0, ovf = udf = 0. Hence empty=1, full=0, almost_empty=1, and almost_full=0 unless AF_LEVEL=0 (disallowed).
- Storage array is not reset. Releasing rst takes effect at the next rising edge of c.
- Pointers are $clog2(DEPTH)+1 bits wide, with the MSB used as a wrap bit. full/empty are derived from the pointers or the count, so all DEPTH entries are usable; no slot is sacrificed.
- Pointer index wraps modulo DEPTH with no special case.
- Read accepted (rd_ok) = r && !empty.
- Write accepted (wr_ok) = w && (!full || rd_ok).
- At full with r=w=1, both are accepted: the oldest word goes to o and i is written into the freed slot. count stays DEPTH.
- At empty with r=w=1, only the write is accepted. udf sets, o holds, count becomes 1. There is no fall-through.
- rd_ok: o <= mem[rd_ptr] at the next edge, so data is valid the cycle after the r edge (latency 1); rd_ptr increments.
- No rd_ok: o holds its previous value.
- wr_ok: mem[wr_ptr] <= i; wr_ptr increments.
- count update per edge: +1 for wr_ok only, -1 for rd_ok only, unchanged for both or neither.
- All flags are combinational from registered state, so they are valid in the same cycle as count.
- ovf sets on w && !wr_ok; udf sets on r && empty. Both stay set until clr or rst.
- clr=1 at an edge: pointers and count return to 0, ovf and udf clear, o holds. clr has priority over r and w in the same cycle, and both are ignored.
- Reset asserted mid-transfer: state is lost immediately and asynchronously. Words in flight are discarded, and no ovf/udf is raised for them.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release -> o=0, count=0, empty=1, almost_empty=1, full=0, ovf=udf=0.
- Fill to full: WIDTH=8, DEPTH=16; write 0x00..0x0F on 16 consecutive cycles -> count steps 1..16; almost_full rises when count=12; full=1 after the 16th write. A 17th write of 0xAA sets ovf=1 and count stays 16.
- Drain in order: from the full state, read 16 times -> o = 0x00..0x0F, each appearing the cycle after its r edge; empty=1 after the last read. A 17th read sets udf=1 and o holds 0x0F.
- Simultaneous read and write at full and at empty:
  - Full (contents 0x00..0x0F), r=w=1 with i=0x55 -> o=0x00, count=16, and 0x55 is later read out after 0x0F.
  - Empty, r=w=1 with i=0x33 -> count=1, udf=1, and the next read returns 0x33.
- Pointer wrap: loop 40 cycles of write-then-read with i=k -> each o equals the value written one cycle earlier. count alternates between 1 and 0, and the pointers pass index 15->0 without error.
- clr and asynchronous reset mid-operation:
  - With count=5 and ovf=1, pulse clr together with w=1 -> count=0, ovf=0, empty=1, the write is ignored, and o holds.
  - Then write 3 words and assert rst between edges -> count=0 and o=0 immediately, with no wait for the clock edge.
